// File: rtl/vpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vpu_pkg
// Description : Shared video-pipeline constants and the bg FIFO filler state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vpu_pkg;

    localparam int H_MAX  = 640;   // pixels per line
    localparam int V_MAX  = 480;   // lines per frame
    localparam int DATA_W = 16;    // pixel width
    localparam int ADDR_W = 19;    // framebuffer word address width

    // Filler sequencing: wait for enable, latch base, stream reads, wait for
    // the tail of the frame to land in the FIFO.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FETCH = 2'd2,
        DRAIN = 2'd3
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/rd_latency_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rd_latency_pipe
// Description : Tracks fixed-latency memory reads with a valid shift register
//               and registers the returned word toward the FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_latency_pipe #(
    parameter int MEM_LATENCY = 2,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd_en,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_wr_en,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_busy
);

    logic [MEM_LATENCY-1:0] r_valid;
    logic                   r_wr_en;
    logic [DATA_W-1:0]      r_wr_data;

    // Shift a valid bit alongside each read; the last stage marks the cycle
    // in which the memory presents that read's data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= i_rd_en;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Capture returned data into the FIFO write register; data is only
    // loaded when a tracked read is due so stale bus values never propagate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= r_valid[MEM_LATENCY-1];
            if (r_valid[MEM_LATENCY-1]) begin
                r_wr_data <= i_rd_data;
            end
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_data = r_wr_data;
    assign o_busy    = i_rd_en | (|r_valid) | r_wr_en;

endmodule
`default_nettype wire

// File: rtl/bg_fifo_filler.sv
`default_nettype none
// ============================================================================
// Module      : bg_fifo_filler
// Description : Walks the background framebuffer in raster order, issues
//               fixed-latency reads and writes the pixels into the bg FIFO
//               under a credit check against the FIFO fill level.
// Revision    : 1.0 - initial release
// ============================================================================
module bg_fifo_filler #(
    parameter int H_MAX       = vpu_pkg::H_MAX,
    parameter int V_MAX       = vpu_pkg::V_MAX,
    parameter int DATA_W      = vpu_pkg::DATA_W,
    parameter int ADDR_W      = vpu_pkg::ADDR_W,
    parameter int MEM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 1024,
    parameter int USEDW_W     = 10,
    parameter int FIFO_MARGIN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_rd_data,
    input  logic [USEDW_W-1:0] fifo_usedw,
    output logic               fifo_wr_en,
    output logic [DATA_W-1:0]  fifo_wr_data,
    output logic [9:0]         fetch_x,
    output logic [8:0]         fetch_y,
    output logic               frame_done
);

    import vpu_pkg::*;

    // Credit sum is two bits wider than usedw so usedw + inflight never wraps.
    localparam int SUM_W  = USEDW_W + 2;
    localparam int INFL_W = USEDW_W + 1;

    localparam logic [SUM_W-1:0] C_CREDIT_LIMIT = SUM_W'(FIFO_DEPTH - FIFO_MARGIN);
    localparam logic [9:0]       C_X_LAST       = 10'(H_MAX - 1);
    localparam logic [8:0]       C_Y_LAST       = 9'(V_MAX - 1);

    fill_state_t         r_state;
    fill_state_t         w_state_next;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_rd_en;
    logic [9:0]          r_fetch_x;
    logic [8:0]          r_fetch_y;
    logic [INFL_W-1:0]   r_inflight;

    logic [SUM_W-1:0]    w_credit_sum;
    logic                w_credit_ok;
    logic                w_last_pixel;
    logic                w_issue;
    logic                w_frame_done;
    logic                w_pipe_busy;
    logic                w_fifo_wr_en;

    assign w_credit_sum = SUM_W'(fifo_usedw) + SUM_W'(r_inflight);
    assign w_credit_ok  = (w_credit_sum < C_CREDIT_LIMIT);
    assign w_last_pixel = (r_fetch_x == C_X_LAST) && (r_fetch_y == C_Y_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, issue decision and end-of-frame pulse.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                if (enable && w_credit_ok) begin
                    w_issue = 1'b1;
                    if (w_last_pixel) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((r_inflight == '0) && !w_pipe_busy) begin
                    w_frame_done = 1'b1;
                    w_state_next = enable ? LOAD : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Raster position, linear read address and the registered read strobe.
    // base_addr is sampled only in LOAD so a mid-frame swap waits a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_addr  <= '0;
            r_mem_addr  <= '0;
            r_mem_rd_en <= 1'b0;
            r_fetch_x   <= '0;
            r_fetch_y   <= '0;
        end else begin
            r_mem_rd_en <= w_issue;
            if (r_state == LOAD) begin
                r_cur_addr <= base_addr;
                r_fetch_x  <= '0;
                r_fetch_y  <= '0;
            end else if (w_issue) begin
                r_mem_addr <= r_cur_addr;
                r_cur_addr <= r_cur_addr + ADDR_W'(1);
                if (r_fetch_x == C_X_LAST) begin
                    r_fetch_x <= '0;
                    r_fetch_y <= (r_fetch_y == C_Y_LAST) ? 9'd0 : r_fetch_y + 9'd1;
                end else begin
                    r_fetch_x <= r_fetch_x + 10'd1;
                end
            end
        end
    end

    // Reads issued but not yet written to the FIFO; counted from the issue
    // decision so the credit check already sees a read on the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_fifo_wr_en})
                2'b10:   r_inflight <= r_inflight + INFL_W'(1);
                2'b01:   r_inflight <= r_inflight - INFL_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    rd_latency_pipe #(
        .MEM_LATENCY (MEM_LATENCY),
        .DATA_W      (DATA_W)
    ) u_rd_latency_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_rd_en   (r_mem_rd_en),
        .i_rd_data (mem_rd_data),
        .o_wr_en   (w_fifo_wr_en),
        .o_wr_data (fifo_wr_data),
        .o_busy    (w_pipe_busy)
    );

    assign mem_rd_en  = r_mem_rd_en;
    assign mem_addr   = r_mem_addr;
    assign fifo_wr_en = w_fifo_wr_en;
    assign fetch_x    = r_fetch_x;
    assign fetch_y    = r_fetch_y;
    assign frame_done = w_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_bg_fifo_filler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bg_fifo_filler
// Description : Self-checking bench for bg_fifo_filler: memory model returning
//               data = address, FIFO occupancy model, and a frame-level
//               reference of the expected read/write stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bg_fifo_filler;

    localparam int H       = 4;
    localparam int V       = 2;
    localparam int L       = 2;
    localparam int DEPTH   = 16;
    localparam int MARGIN  = 4;
    localparam int UW      = 10;
    localparam int DW      = 16;
    localparam int AW      = 19;
    localparam int NPIX    = H * V;
    localparam int OCC_MAX = DEPTH - MARGIN + L + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [AW-1:0] base_addr;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [UW-1:0] fifo_usedw = '0;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic [9:0]    fetch_x;
    logic [8:0]    fetch_y;
    logic          frame_done;

    bg_fifo_filler #(
        .H_MAX       (H),
        .V_MAX       (V),
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .MEM_LATENCY (L),
        .FIFO_DEPTH  (DEPTH),
        .USEDW_W     (UW),
        .FIFO_MARGIN (MARGIN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .base_addr    (base_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .fifo_usedw   (fifo_usedw),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fetch_x      (fetch_x),
        .fetch_y      (fetch_y),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory model: a read seen during cycle k returns its address as data
    // from the middle of cycle k+L, so it is captured on the edge after.
    logic [AW-1:0] dl_a [0:L];
    logic          dl_v [0:L];
    initial for (int i = 0; i <= L; i++) begin dl_a[i] = '0; dl_v[i] = 1'b0; end
    always @(negedge clk) begin
        for (int i = L; i > 0; i--) begin
            dl_a[i] = dl_a[i-1];
            dl_v[i] = dl_v[i-1];
        end
        dl_a[0] = mem_addr;
        dl_v[0] = mem_rd_en;
        mem_rd_data = dl_v[L] ? dl_a[L][DW-1:0] : 16'hDEAD;
    end

    // Reference model of the frame stream.
    typedef struct { logic [AW-1:0] addr; int cyc; } rd_t;
    rd_t q[$];
    int  cyc = 0, pix_idx = 0, frame_wr = 0, frames_done = 0, total_issues = 0;
    int  last_wr_cyc = 0, first_issue_cyc = 0, span = 0, done_span = 0;
    int  usedw_force = 0, occ = 0;
    bit  rand_mode = 1'b0;
    logic [AW-1:0] frame_base = '0, first_addr = '0, done_first_addr = '0;

    always @(negedge clk) begin
        rd_t           e;
        int            nxt;
        logic [AW-1:0] exp_a;
        cyc++;
        // usedw presented to the DUT trails the model occupancy by one cycle.
        fifo_usedw = rand_mode ? UW'(occ) : UW'(usedw_force);
        if (rst) begin
            q.delete();
            pix_idx  = 0;
            frame_wr = 0;
        end else begin
            if (mem_rd_en) begin
                if (pix_idx == 0) begin
                    frame_base      = base_addr;
                    first_issue_cyc = cyc;
                    first_addr      = mem_addr;
                end
                exp_a = frame_base + AW'(pix_idx);
                check("rd_addr", 32'(mem_addr), 32'(exp_a));
                pix_idx++;
                nxt = pix_idx % NPIX;
                check("fetch_x", 32'(fetch_x), nxt % H);
                check("fetch_y", 32'(fetch_y), nxt / H);
                if (pix_idx == NPIX) begin
                    pix_idx = 0;
                    span    = cyc - first_issue_cyc;
                end
                e.addr = mem_addr;
                e.cyc  = cyc;
                q.push_back(e);
                total_issues++;
            end
            if (fifo_wr_en) begin
                if (q.size() == 0) begin
                    check("stray_wr", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("wr_data", 32'(fifo_wr_data), 32'(e.addr[DW-1:0]));
                    check("wr_latency", cyc - e.cyc, L + 1);
                end
                frame_wr++;
                last_wr_cyc = cyc;
                check("wr_per_frame", 32'(frame_wr <= NPIX), 1);
                if (rand_mode) begin
                    occ++;
                    check("occ_bound", 32'(occ <= OCC_MAX), 1);
                end
            end
            if (frame_done) begin
                check("fd_writes", frame_wr, NPIX);
                check("fd_gap", 32'((cyc - last_wr_cyc) >= 1 && (cyc - last_wr_cyc) <= 2), 1);
                check("fd_q_empty", q.size(), 0);
                frame_wr        = 0;
                frames_done++;
                done_first_addr = first_addr;
                done_span       = span;
            end
            if (rand_mode && occ > 0 && $urandom_range(0, 99) < 45) occ--;
        end
    end

    task automatic wait_pix(input int n, input string tag);
        int i = 0;
        while (pix_idx != n && i < 200) begin tick(); i++; end
        check(tag, 32'(pix_idx == n), 1);
    endtask

    task automatic wait_frames(input int n, input string tag);
        int i = 0;
        while (frames_done < n && i < 400) begin tick(); i++; end
        check(tag, 32'(frames_done >= n), 1);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        enable    = 1'b0;
        base_addr = 19'h00100;
        repeat (3) tick();
        check("rst_mem_rd_en", 32'(mem_rd_en), 0);
        check("rst_fifo_wr_en", 32'(fifo_wr_en), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_fetch_x", 32'(fetch_x), 0);
        check("rst_fetch_y", 32'(fetch_y), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        rst = 1'b0;

        // Credit: full at usedw=12, room for exactly one at usedw=11.
        usedw_force = 12;
        enable      = 1'b1;
        repeat (13) tick();
        check("stall_at_12", total_issues, 0);
        usedw_force = 11;
        tick();
        repeat (4) tick();
        check("one_at_11", total_issues, 1);
        usedw_force = 0;

        // Swap base mid-frame; takes effect only on the next frame.
        wait_pix(3, "wait_f1_mid");
        base_addr = 19'h00200;
        wait_frames(1, "wait_f1");
        check("f1_base", 32'(done_first_addr), 32'h100);
        wait_frames(2, "wait_f2");
        check("f2_base", 32'(done_first_addr), 32'h200);
        check("f2_back_to_back", done_span, NPIX - 1);

        // Pause mid-line at x=2.
        wait_pix(2, "wait_f3_x2");
        enable = 1'b0;
        n = total_issues;
        repeat (5) tick();
        check("pause_no_issue", total_issues, n);
        check("pause_x", 32'(fetch_x), 2);
        check("pause_y", 32'(fetch_y), 0);
        check("pause_drained", q.size(), 0);
        enable = 1'b1;
        wait_frames(3, "wait_f3");

        // Reset mid-frame with reads outstanding; next base wraps the space.
        wait_pix(3, "wait_f4_mid");
        check("rst_has_inflight", 32'(q.size() >= 2), 1);
        rst = 1'b1;
        #1;
        check("arst_mem_rd_en", 32'(mem_rd_en), 0);
        check("arst_fifo_wr_en", 32'(fifo_wr_en), 0);
        check("arst_fetch_x", 32'(fetch_x), 0);
        check("arst_frame_done", 32'(frame_done), 0);
        base_addr = 19'h7FFFD;
        repeat (2) tick();
        rst = 1'b0;
        wait_frames(4, "wait_f5");
        check("f5_base_wrap", 32'(done_first_addr), 32'h7FFFD);

        // Randomised backpressure, enable and base swaps.
        occ       = 0;
        rand_mode = 1'b1;
        for (int i = 0; i < 6000 && frames_done < 14; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if (pix_idx >= 2 && pix_idx <= 5 && $urandom_range(0, 4) == 0)
                base_addr = AW'($urandom);
            tick();
        end
        enable = 1'b1;
        wait_frames(14, "rand_frames");
        enable = 1'b0;
        repeat (20) tick();
        check("final_q_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bg_fifo_filler.md
Name: bg_fifo_filler

Overview:
Producer side of the background pixel FIFO. It walks the background framebuffer in raster order (x 0..H_MAX-1, y 0..V_MAX-1), issues fixed-latency memory reads, and writes the returned pixels into the bg FIFO. The pixel counter drains that FIFO at display rate; this block keeps it filled without overflowing it.

Parameters:
H_MAX, 640, pixels per line
V_MAX, 480, lines per frame
DATA_W, 16, pixel width
ADDR_W, 19, framebuffer word address width
MEM_LATENCY, 2, cycles from mem_rd_en to mem_rd_data valid (≥1)
FIFO_DEPTH, 1024, bg FIFO depth in words
USEDW_W, 10, width of fifo_usedw
FIFO_MARGIN, 4, words kept free to absorb the usedw lag

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  allow new reads to be issued
base_addr  in  ADDR_W  framebuffer base; sampled only at frame start
mem_rd_en  out  1  read strobe, one word per cycle
mem_addr  out  ADDR_W  read address
mem_rd_data  in  DATA_W  read data, valid MEM_LATENCY cycles after mem_rd_en
fifo_usedw  in  USEDW_W  FIFO fill level (may lag writes by 1 cycle)
fifo_wr_en  out  1  FIFO write strobe
fifo_wr_data  out  DATA_W  pixel to FIFO
fetch_x  out  10  x of the next pixel to issue
fetch_y  out  9  y of the next pixel to issue
frame_done  out  1  one-cycle pulse when the last pixel of a frame is written

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; all outputs 0; inflight count 0; the valid pipeline is cleared.
  - Reads in flight at reset are discarded. Data arriving after reset release is ignored because its valid bit was cleared.
- States: IDLE, LOAD, FETCH, DRAIN.
  - IDLE: when enable=1, go to LOAD.
  - LOAD, one cycle: latch base_addr into cur_addr; fetch_x=0, fetch_y=0; go to FETCH.
  - FETCH: issue a read when enable=1 and (fifo_usedw + inflight) < FIFO_DEPTH - FIFO_MARGIN. Compute the sum at USEDW_W+2 bits so it cannot overflow.
  - On an issue: mem_rd_en=1, mem_addr=cur_addr; then cur_addr+1, and fetch_x+1, wrapping to 0 with fetch_y+1 at H_MAX-1.
  - The issue for x=H_MAX-1, y=V_MAX-1 moves the state to DRAIN. fetch_x and fetch_y return to 0.
  - DRAIN: no issues. When inflight==0 and the valid pipeline is empty, pulse frame_done. Go to LOAD if enable=1, else IDLE.
- Address arithmetic:
  - Linear, cur_addr increments by 1 per issued read; no multiplier.
  - Wraps modulo 2^ADDR_W.
  - base_addr changes during a frame have no effect until the next LOAD (double-buffer swap point).
- Read pipeline:
  - A valid shift register of MEM_LATENCY stages tracks issued reads.
  - At stage end: fifo_wr_en=1, fifo_wr_data=mem_rd_data, registered so there is one extra cycle.
  - Total latency from issue to fifo_wr_en: MEM_LATENCY+1 cycles.
  - inflight = issued reads not yet written. It increments on issue and decrements on write. When both happen in the same cycle, it is unchanged.
- Backpressure:
  - When the credit check fails, stall issuing; the in-flight reads still complete.
  - The FIFO never receives more than FIFO_DEPTH - FIFO_MARGIN + MEM_LATENCY + 1 outstanding words.
- enable=0 in FETCH: issuing pauses; position holds; pipeline drains; resumes on the next cycle enable=1.
- enable=0 in DRAIN: the frame still completes and frame_done still pulses; then go to IDLE.
- Pixel order in the FIFO equals issue order; no reordering.

Decomposition:
- Shared package (vpu_pkg): H_MAX, V_MAX, DATA_W, ADDR_W; the state enum (IDLE, LOAD, FETCH, DRAIN).
- Sub-module rd_latency_pipe (valid shift register plus output data register) is natural. The top holds the FSM, counters and credit logic.

Test Plan:
1. H_MAX=4, V_MAX=2, MEM_LATENCY=2, base_addr=0x100, enable=1, usedw=0 held -> mem_addr 0x100..0x107 on 8 consecutive cycles after LOAD. First fifo_wr_en 3 cycles after the first mem_rd_en. frame_done pulses once after the 8th write, then the next frame restarts at the newly sampled base.
2. FIFO_DEPTH=16, FIFO_MARGIN=4, usedw forced to 11 -> at most 1 read issued while inflight=0; usedw=12 -> no issues. Release to 0 -> issuing resumes with no skipped or duplicated addresses.
3. Drop enable for 5 cycles mid-line at x=2 -> in-flight words still written; position holds; resume at x=2 with the correct address.
4. Change base_addr mid-frame -> current frame addresses unaffected; the next frame starts at the new base.
5. Assert rst mid-frame with 2 reads in flight -> outputs 0 immediately. After release, no stale fifo_wr_en; a fresh frame starts at x=0, y=0.
6. Memory model returns data equal to address -> FIFO content sequence equals base..base+H_MAX*V_MAX-1 in order, with usedw backpressure randomized.
